hls_fp17_add_core_chn_o_rsci_xmit: RTL and testbench
====================================================

# hls_fp17_add_core_chn_o_rsci_xmit

Transmit-side wait controller and data path for the fp17 adder output channel `chn_o`. The block presents the core's 17-bit result to the downstream consumer with a valid/ready handshake and holds valid and data stable across consumer back-pressure. It records a completed transfer until the core pipeline is enabled to observe it. It sits between the HLS core datapath and the outbound `chn_o` port, mirroring the receive-side controllers on the input channels.

## Interface
Parameters:
- `WIDTH`, 17, data width of `chn_o`.

Ports:
- `nvdla_core_clk`, in, 1: clock. All state updates on the rising edge.
- `nvdla_core_rstn`, in, 1: asynchronous, active-low reset.
- `chn_o_rsci_oswt`, in, 1: core wants to complete an output transfer in this stage.
- `core_wen`, in, 1: core pipeline enable.
- `core_wten`, in, 1: core wait/stall indicator.
- `chn_o_rsci_iswt0`, in, 1: core issues a new output transfer.
- `chn_o_rsci_ld_core_psct`, in, 1: core pre-select for the load strobe.
- `core_data_in`, in, WIDTH: result from the core datapath.
- `chn_o_rdy`, in, 1: downstream ready.
- `chn_o_vld`, out, 1: valid to downstream.
- `chn_o_data`, out, WIDTH: data to downstream.
- `chn_o_rsci_ld_core_sct`, out, 1: qualified load strobe.
- `chn_o_rsci_bawt`, out, 1: transfer complete and available to the core.
- `chn_o_rsci_wen_comp`, out, 1: core may advance with respect to this channel.

## Operation
State registers:
- `icwt`: issued, still waiting for ready.
- `bcwt`: completed, not yet consumed by the core.
- `data_q[WIDTH-1:0]`: holds the data for an outstanding transfer.

Combinational terms:
- `pdswt0 = ~core_wten & chn_o_rsci_iswt0`
- `ogwt = pdswt0 | icwt`
- `chn_o_vld = ogwt`
- `chn_o_rsci_ld_core_sct = chn_o_rsci_ld_core_psct & ogwt`
- `biwt = ogwt & chn_o_rdy` (handshake fires)
- `bdwt = chn_o_rsci_oswt & core_wen` (core consumes the completion)
- `chn_o_rsci_bawt = biwt | bcwt`
- `chn_o_rsci_wen_comp = ~chn_o_rsci_oswt | chn_o_rsci_bawt`
- `chn_o_data = icwt ? data_q : core_data_in`

Next-state rules:
- `icwt <= ogwt & ~biwt`.
- `bcwt <= (bcwt | biwt) & ~bdwt`.
- `data_q <= core_data_in` when `pdswt0 & ~icwt`. Otherwise `data_q` holds.

Boundary conditions:
- **Issue and ready in the same cycle:** the transfer completes with zero wait. `icwt` stays 0, `data_q` still loads (don't-care), and `bcwt` sets unless `bdwt` is also 1.
- **`pdswt0` while `icwt=1`:** protocol violation by the core. `data_q` is not reloaded, valid stays 1, and no second transfer is queued. The bench flags this with an assertion.
- **`biwt` and `bdwt` in the same cycle:** `bcwt` stays or goes to 0.
- **Downstream stall (`chn_o_rdy=0`):** `chn_o_vld` and `chn_o_data` stay stable every cycle until `rdy=1`.
- **Data stability:** data never changes while `chn_o_vld=1` and `chn_o_rdy=0`, once `icwt=1`.

## Timing
- **Reset:** asserting `nvdla_core_rstn` low clears `icwt`, `bcwt` and `data_q` immediately, without waiting for a clock edge. This applies mid-transfer as well; an outstanding transfer is dropped.
- **Outputs in reset:** `chn_o_vld` follows `pdswt0` only, so it is 0 when `iswt0=0`. `chn_o_rsci_bawt` is 0 and `chn_o_data` equals `core_data_in`.
- **Latency:** valid is combinational from issue (0 cycles). A completion is visible on `bawt` in the same cycle as the handshake and persists from the next cycle via `bcwt` until consumed.
- **Throughput:** one transfer per cycle when `chn_o_rdy` is held high.
- **Reset release:** synchronised externally; the first edge after deassert may update state.

## Test plan
- **Reset mid-wait:** issue `0x1ABCD` with `rdy=0` for 2 cycles, then assert rstn low. Response: `icwt`, `bcwt` and `vld` go to 0 immediately. After release with `iswt0=0`: `vld=0`, `bawt=0`.
- **Zero-wait transfer:** `iswt0=1`, `core_wten=0`, `rdy=1`, `core_data_in=0x00123`, `oswt=1`, `core_wen=1`. Response: `vld=1`, `data=0x00123`, `bawt=1`, `wen_comp=1` in the same cycle. Next cycle (`iswt0=0`): `vld=0`, `bcwt=0`.
- **Back-pressure hold:** issue `0x1FFFF`, then `rdy=0` for 3 cycles while `core_wten=1` and `core_data_in` toggles to `0x00000`. Response: `vld=1` and `data=0x1FFFF` on all 3 cycles. Raise `rdy`: handshake fires, and `icwt=0` on the next cycle.
- **Deferred consume:** handshake with `core_wen=0`. Response: `bcwt=1` next cycle and `bawt=1` held until `oswt=1 & core_wen=1`, then `bcwt=0` the following cycle.
- **Back-to-back:** 8 consecutive issues, values `0x00001..0x00008`, `rdy=1`. Response: 8 handshakes in 8 cycles, in order, with no `icwt` set.
- **Random stress:** random `rdy`, issue only when the core is not stalled, and a scoreboard. Response: every issued value appears exactly once and in order; data is stable under a stall.

Source files
------------

// File: rtl/hls_fp17_add_core_chn_o_rsci_xmit.sv
// Purpose: transmit-side wait controller and data holding register for the fp17 adder output channel chn_o.
// Latency: valid and data are combinational from issue (0 cycles); completion shows on bawt in the handshake cycle.
// Backpressure: while chn_o_rdy is low an issued transfer is held (valid and data stable) until the handshake.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn  clock, asynchronous active-low reset
//   chn_o_rsci_oswt, core_wen         core wants to complete / pipeline enable (together they consume a completion)
//   core_wten, chn_o_rsci_iswt0       core stall, core issues a new transfer
//   chn_o_rsci_ld_core_psct           pre-select for the load strobe chn_o_rsci_ld_core_sct
//   core_data_in                      result from the core datapath
//   chn_o_vld / chn_o_rdy / chn_o_data downstream valid-ready channel
//   chn_o_rsci_bawt                   transfer complete and available to the core
//   chn_o_rsci_wen_comp               core may advance with respect to this channel
module hls_fp17_add_core_chn_o_rsci_xmit #(
    parameter int WIDTH = 17
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             chn_o_rsci_oswt,
    input  logic             core_wen,
    input  logic             core_wten,
    input  logic             chn_o_rsci_iswt0,
    input  logic             chn_o_rsci_ld_core_psct,
    input  logic [WIDTH-1:0] core_data_in,
    input  logic             chn_o_rdy,
    output logic             chn_o_vld,
    output logic [WIDTH-1:0] chn_o_data,
    output logic             chn_o_rsci_ld_core_sct,
    output logic             chn_o_rsci_bawt,
    output logic             chn_o_rsci_wen_comp
);

    // icwt: issued and still waiting for ready
    // bcwt: completed but not yet consumed by the core
    logic             icwt_q, icwt_d;
    logic             bcwt_q, bcwt_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic pdswt0;
    logic ogwt;
    logic biwt;
    logic bdwt;

    always_comb begin
        pdswt0 = ~core_wten & chn_o_rsci_iswt0;
        ogwt   = pdswt0 | icwt_q;
        biwt   = ogwt & chn_o_rdy;
        bdwt   = chn_o_rsci_oswt & core_wen;

        chn_o_vld              = ogwt;
        chn_o_rsci_ld_core_sct = chn_o_rsci_ld_core_psct & ogwt;
        chn_o_rsci_bawt        = biwt | bcwt_q;
        chn_o_rsci_wen_comp    = ~chn_o_rsci_oswt | chn_o_rsci_bawt;
        // While waiting, the captured value is presented so the core's datapath may move on.
        chn_o_data             = icwt_q ? data_q : core_data_in;
    end

    always_comb begin
        icwt_d = ogwt & ~biwt;
        bcwt_d = (bcwt_q | biwt) & ~bdwt;
        data_d = data_q;
        // Only a fresh issue captures data; an issue while already waiting is a core
        // protocol violation and must not overwrite the outstanding value.
        if (pdswt0 & ~icwt_q) begin
            data_d = core_data_in;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            icwt_q <= 1'b0;
            bcwt_q <= 1'b0;
            data_q <= '0;
        end else begin
            icwt_q <= icwt_d;
            bcwt_q <= bcwt_d;
            data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_hls_fp17_add_core_chn_o_rsci_xmit.sv
module tb_hls_fp17_add_core_chn_o_rsci_xmit;

    localparam int WIDTH = 17;

    logic             clk = 1'b0;
    logic             rstn;
    logic             oswt, wen, wten, iswt0, psct, rdy;
    logic [WIDTH-1:0] din;
    logic             vld, ld_sct, bawt, wen_comp;
    logic [WIDTH-1:0] dout;

    int n_cmp = 0;
    int n_err = 0;
    int n_hs  = 0;

    logic [WIDTH-1:0] sb[$];
    logic             m_icwt = 1'b0;

    always #5 clk = ~clk;

    hls_fp17_add_core_chn_o_rsci_xmit #(.WIDTH(WIDTH)) dut (
        .nvdla_core_clk          (clk),
        .nvdla_core_rstn         (rstn),
        .chn_o_rsci_oswt         (oswt),
        .core_wen                (wen),
        .core_wten               (wten),
        .chn_o_rsci_iswt0        (iswt0),
        .chn_o_rsci_ld_core_psct (psct),
        .core_data_in            (din),
        .chn_o_rdy               (rdy),
        .chn_o_vld               (vld),
        .chn_o_data              (dout),
        .chn_o_rsci_ld_core_sct  (ld_sct),
        .chn_o_rsci_bawt         (bawt),
        .chn_o_rsci_wen_comp     (wen_comp)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkd(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: expected values are pushed when a legal issue is driven,
    // popped when a handshake is observed. m_icwt tracks an outstanding transfer.
    always @(negedge clk) begin
        logic issue;
        if (!rstn) begin
            sb.delete();
            m_icwt = 1'b0;
        end else begin
            issue = !wten && iswt0;
            check1("mon_vld", vld, issue || m_icwt);
            if (m_icwt && sb.size() != 0) begin
                checkd("mon_hold_data", dout, sb[0]);
            end
            if (issue && !m_icwt) begin
                sb.push_back(din);
            end
            if (vld && rdy) begin
                n_hs++;
                check1("mon_hs_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    checkd("mon_hs_data", dout, sb.pop_front());
                end
            end
            m_icwt = (issue || m_icwt) && !rdy;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        oswt = 1'b0; wen = 1'b0; wten = 1'b0; iswt0 = 1'b0; psct = 1'b0; rdy = 1'b0;
    endtask

    initial begin
        int hs0;
        rstn = 1'b0;
        idle();
        din = 17'h0AAAA;

        // Reset state
        cyc(); cyc();
        #1;
        check1("rst_vld", vld, 1'b0);
        check1("rst_bawt", bawt, 1'b0);
        checkd("rst_data_passthru", dout, 17'h0AAAA);
        check1("rst_wen_comp", wen_comp, 1'b1);
        iswt0 = 1'b1;
        #1;
        check1("rst_vld_follows_issue", vld, 1'b1);
        iswt0 = 1'b0;
        cyc();
        rstn = 1'b1;
        cyc();

        // Reset mid-wait
        iswt0 = 1'b1; din = 17'h1ABCD; rdy = 1'b0;
        #1;
        check1("rmw_vld0", vld, 1'b1);
        checkd("rmw_data0", dout, 17'h1ABCD);
        cyc();
        iswt0 = 1'b0; din = 17'h00000;
        #1;
        check1("rmw_vld1", vld, 1'b1);
        checkd("rmw_data1", dout, 17'h1ABCD);
        cyc();
        rstn = 1'b0; din = 17'h05555;
        #1;
        check1("rmw_vld_async", vld, 1'b0);
        check1("rmw_bawt_async", bawt, 1'b0);
        checkd("rmw_data_async", dout, 17'h05555);
        cyc();
        rstn = 1'b1;
        cyc();
        #1;
        check1("rmw_vld_post", vld, 1'b0);
        check1("rmw_bawt_post", bawt, 1'b0);

        // Zero-wait transfer with immediate consume
        iswt0 = 1'b1; din = 17'h00123; rdy = 1'b1; oswt = 1'b1; wen = 1'b1; psct = 1'b1;
        #1;
        check1("zw_vld", vld, 1'b1);
        checkd("zw_data", dout, 17'h00123);
        check1("zw_bawt", bawt, 1'b1);
        check1("zw_wen_comp", wen_comp, 1'b1);
        check1("zw_ld_sct", ld_sct, 1'b1);
        cyc();
        idle();
        #1;
        check1("zw_vld_next", vld, 1'b0);
        check1("zw_bawt_next", bawt, 1'b0);
        check1("zw_ld_sct_next", ld_sct, 1'b0);
        oswt = 1'b1;
        #1;
        check1("wen_comp_blocked", wen_comp, 1'b0);
        oswt = 1'b0;
        cyc();

        // Back-pressure hold
        iswt0 = 1'b1; din = 17'h1FFFF;
        #1;
        check1("bp_vld_issue", vld, 1'b1);
        cyc();
        wten = 1'b1; din = 17'h00000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check1("bp_vld_hold", vld, 1'b1);
            checkd("bp_data_hold", dout, 17'h1FFFF);
            check1("bp_bawt_hold", bawt, 1'b0);
            cyc();
        end
        rdy = 1'b1;
        #1;
        check1("bp_bawt_hs", bawt, 1'b1);
        checkd("bp_data_hs", dout, 17'h1FFFF);
        cyc();

        // Deferred consume (completion from the handshake above, core_wen=0)
        idle();
        #1;
        check1("bp_vld_after", vld, 1'b0);
        check1("dc_bawt_held0", bawt, 1'b1);
        cyc();
        oswt = 1'b1; wen = 1'b0;
        #1;
        check1("dc_bawt_held1", bawt, 1'b1);
        check1("dc_wen_comp", wen_comp, 1'b1);
        cyc();
        wen = 1'b1;
        #1;
        check1("dc_bawt_consume", bawt, 1'b1);
        cyc();
        idle();
        #1;
        check1("dc_bawt_cleared", bawt, 1'b0);
        cyc();

        // Protocol violation: issue while already waiting must not reload data
        iswt0 = 1'b1; din = 17'h0AAAA;
        cyc();
        din = 17'h15555;
        #1;
        check1("pv_vld", vld, 1'b1);
        checkd("pv_data_kept", dout, 17'h0AAAA);
        cyc();
        iswt0 = 1'b0; rdy = 1'b1;
        #1;
        checkd("pv_data_hs", dout, 17'h0AAAA);
        check1("pv_bawt", bawt, 1'b1);
        cyc();
        rdy = 1'b0; oswt = 1'b1; wen = 1'b1;
        #1;
        check1("pv_no_second", vld, 1'b0);
        cyc();
        idle();

        // Back-to-back
        hs0 = n_hs;
        rdy = 1'b1; iswt0 = 1'b1; oswt = 1'b1; wen = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            din = WIDTH'(i);
            #1;
            checkd("b2b_data", dout, WIDTH'(i));
            check1("b2b_bawt", bawt, 1'b1);
            cyc();
        end
        idle();
        #1;
        check1("b2b_no_icwt", vld, 1'b0);
        checkd("b2b_hs_count", WIDTH'(n_hs - hs0), 17'd8);
        cyc();

        // Random stress
        for (int i = 0; i < 400; i++) begin
            rdy   = 1'($urandom_range(0, 1));
            wten  = ($urandom_range(0, 3) == 0);
            iswt0 = !m_icwt && ($urandom_range(0, 2) != 0);
            oswt  = 1'($urandom_range(0, 1));
            wen   = 1'($urandom_range(0, 1));
            psct  = 1'($urandom_range(0, 1));
            din   = WIDTH'($urandom);
            cyc();
        end
        idle();
        rdy = 1'b1;
        cyc(); cyc();
        rdy = 1'b0;
        #1;
        checkd("rand_sb_drained", WIDTH'(sb.size()), 17'd0);
        check1("rand_vld_idle", vld, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
